out_handshake_sink: RTL and testbench
=====================================

Name: out_handshake_sink

Overview:
Parametrised consumer for the FIFO_to_out start/finish handshake. It replaces the ad-hoc capture FSM in the UART test tops. Each accepted word is captured into a DEPTH-entry history and folded into a running CRC. It has a programmable acknowledge width, a freeze mode that applies backpressure, and a selectable view word for the SevenSegment display.

Parameters:
WIDTH, 8, data word width
DEPTH, 4, history entries (2..16)
SELW, 2, width of view_sel; 2**SELW >= DEPTH
ACK_CYCLES, 1, cycles out_finish is held high per word (1..15)
CRC_POLY, 8'h07, CRC polynomial, WIDTH bits, MSB-first, init 0

Ports:
clk  in  1  system clock (UART-rate clock in the test tops)
reset  in  1  synchronous, active-low reset
enable  in  1  permits new captures; sampled in IDLE only
freeze  in  1  0 = rolling history (oldest dropped); 1 = stop accepting once full
clear  in  1  synchronous clear of history, CRC, counters
out_start  in  1  producer word-valid level (from FIFO_to_out)
out_data  in  WIDTH  producer word
out_finish  out  1  acknowledge to producer, registered
view_sel  in  SELW  history index; 0 = newest
view_data  out  WIDTH  history[view_sel]; 0 if index >= valid_count
crc  out  WIDTH  running CRC over all accepted words
byte_count  out  16  accepted words, saturates at 16'hFFFF
valid_count  out  5  valid history entries, 0..DEPTH
full  out  1  valid_count == DEPTH
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset==0 at a clk edge):
  - all outputs 0 and history zeroed
  - FSM to IDLE
  - reset has priority over everything, including an in-flight handshake
- FSM states: IDLE, ACK, GAP.
- IDLE:
  - Accept when enable && out_start && !(freeze && full).
  - On an accept edge: history shifts (h[i] <= h[i-1]), h[0] <= out_data.
  - crc <= crc_step(crc, out_data).
  - byte_count increments (saturating); valid_count increments up to DEPTH.
  - ack counter loads ACK_CYCLES; state goes to ACK.
  - Otherwise stay in IDLE with out_finish=0.
- ACK:
  - out_finish=1.
  - Counter decrements each cycle; at counter==1 go to GAP.
  - out_finish is therefore high for exactly ACK_CYCLES cycles, starting the cycle after the accept edge.
- GAP:
  - out_finish=0 for exactly 1 cycle, then IDLE.
  - out_start still high on return to IDLE counts as a new word. The producer must drop out_start while out_finish is high.
- Latency:
  - accept edge N: history, crc, counts and view_data are updated after edge N
  - out_finish high N+1..N+ACK_CYCLES
  - earliest next accept at edge N+ACK_CYCLES+2
- crc_step: bitwise over WIDTH bits, MSB-first. c = crc ^ data; WIDTH times: c = c[MSB] ? (c<<1)^CRC_POLY : c<<1. Single cycle, combinational.
- freeze:
  - freeze=1 && full: no accept, out_finish stays 0, producer stalls, counts held.
  - freeze=0 && full: the oldest entry is discarded and valid_count stays DEPTH.
- clear:
  - Zeroes history, crc, byte_count, valid_count.
  - FSM state and out_finish are unaffected, so an in-flight ACK completes.
  - clear and an accept on the same edge: clear wins and the word is dropped. The word is still acknowledged (FSM enters ACK) so the producer is not hung.
- enable:
  - Sampled only in IDLE.
  - Dropping enable during ACK/GAP does not abort the handshake.
- view_data: combinational mux of the history registers on view_sel.
- Saturation: byte_count holds at 16'hFFFF. crc keeps updating.

Test Plan:
- Reset then single word: reset low 2 cycles, enable=1, out_start=1 with out_data=8'h31 until out_finish.
  - crc=8'h97, byte_count=1, valid_count=1, view_data(sel 0)=8'h31.
  - out_finish high exactly 1 cycle, then low 1 cycle.
- Two words 8'h01 then 8'h02:
  - crc 8'h07 after the first word, 8'h1B after the second.
  - view_sel=0 gives 8'h02, view_sel=1 gives 8'h01, view_sel=2 gives 0.
- ACK_CYCLES=3:
  - out_finish high 3 consecutive cycles starting 1 cycle after the accept edge.
  - busy high 4 cycles.
  - Holding out_start high throughout captures a second word at accept edge +5.
- Rolling vs freeze, DEPTH=4, words 1..5:
  - freeze=0: history newest-first {5,4,3,2}, valid_count=4, byte_count=5.
  - freeze=1: word 5 is never acknowledged, history {4,3,2,1}, full=1.
  - Then clear: valid_count=0, crc=0, and word 5 is accepted next.
- clear coincident with accept of 8'hAA: crc=0, byte_count=0, history all 0, out_finish still pulses once.
- Reset asserted mid-ACK (ACK_CYCLES=3, second cycle): out_finish=0 on the next edge, all counts 0, busy=0.

Source files
------------

// File: rtl/out_handshake_sink.sv
// rtl/out_handshake_sink.sv - start/finish handshake consumer with history, running CRC and counters
module out_handshake_sink #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 4,
    parameter int               SELW       = 2,
    parameter int               ACK_CYCLES = 1,
    parameter logic [WIDTH-1:0] CRC_POLY   = WIDTH'(8'h07)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             freeze,
    input  logic             clear,
    input  logic             out_start,
    input  logic [WIDTH-1:0] out_data,
    output logic             out_finish,
    input  logic [SELW-1:0]  view_sel,
    output logic [WIDTH-1:0] view_data,
    output logic [WIDTH-1:0] crc,
    output logic [15:0]      byte_count,
    output logic [4:0]       valid_count,
    output logic             full,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        GAP  = 2'd2
    } stateT;

    stateT            state;
    stateT            nextState;
    logic [3:0]       ackCnt;
    logic             finishReg;
    logic             finishNext;
    logic             accept;
    logic             isFull;

    logic [WIDTH-1:0] hist [DEPTH];
    logic [WIDTH-1:0] crcReg;
    logic [15:0]      byteCnt;
    logic [4:0]       validCnt;
    logic [WIDTH-1:0] viewMux;

    // MSB-first CRC of one whole word, folded in a single cycle
    function automatic logic [WIDTH-1:0] crcStep(input logic [WIDTH-1:0] crcIn,
                                                 input logic [WIDTH-1:0] dataIn);
        logic [WIDTH-1:0] c;
        c = crcIn ^ dataIn;
        for (int i = 0; i < WIDTH; i++) begin
            c = c[WIDTH-1] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    assign isFull = (validCnt == 5'(DEPTH));
    // enable and the freeze gate only matter while waiting for a word
    assign accept = (state == IDLE) && enable && out_start && !(freeze && isFull);

    // State register, ack counter and registered acknowledge
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ackCnt    <= '0;
            finishReg <= 1'b0;
        end else begin
            state     <= nextState;
            finishReg <= finishNext;
            if (accept) begin
                ackCnt <= 4'(ACK_CYCLES);
            end else if (state == ACK) begin
                ackCnt <= ackCnt - 4'd1;
            end
        end
    end

    // Next-state decode: ACK lasts ACK_CYCLES, GAP lasts one cycle
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = ACK;
            ACK:     if (ackCnt <= 4'd1) nextState = GAP;
            GAP:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output decode: acknowledge is registered from the upcoming state
    always_comb begin
        finishNext = (nextState == ACK);
        busy       = (state != IDLE);
    end

    // History, CRC and counters; clear only touches this datapath, never the handshake
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
            crcReg   <= '0;
            byteCnt  <= '0;
            validCnt <= '0;
        end else if (accept) begin
            hist[0] <= out_data;
            for (int i = 1; i < DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
            crcReg <= crcStep(crcReg, out_data);
            if (byteCnt != 16'hFFFF) begin
                byteCnt <= byteCnt + 16'd1;
            end
            if (!isFull) begin
                validCnt <= validCnt + 5'd1;
            end
        end
    end

    // View mux: entries beyond the valid count read as zero
    always_comb begin
        viewMux = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((int'(view_sel) == i) && (i < int'(validCnt))) begin
                viewMux = hist[i];
            end
        end
    end

    assign out_finish  = finishReg;
    assign view_data   = viewMux;
    assign crc         = crcReg;
    assign byte_count  = byteCnt;
    assign valid_count = validCnt;
    assign full        = isFull;

endmodule

// File: tb/tb_out_handshake_sink.sv
// tb/tb_out_handshake_sink.sv - scoreboard bench for out_handshake_sink
module tb_out_handshake_sink;

    localparam int DEPTH = 4;
    localparam int ACK3  = 3;

    logic        clk = 1'b0;
    logic        reset, enable, freeze, clear, out_start;
    logic [7:0]  out_data;
    logic        out_finish;
    logic [1:0]  view_sel;
    logic [7:0]  view_data, crc;
    logic [15:0] byte_count;
    logic [4:0]  valid_count;
    logic        full, busy;

    logic        reset3, start3, finish3, full3, busy3;
    logic [7:0]  data3, view3, crc3;
    logic [15:0] count3;
    logic [4:0]  valid3;
    logic        one3 = 1'b1;
    logic        zero3 = 1'b0;
    logic [1:0]  sel3 = 2'd0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  crc;
        logic [15:0] bc;
        logic [4:0]  vc;
        logic [7:0]  v0;
    } expT;

    expT        sbq[$];
    logic [7:0] mHist[$];
    logic [7:0] mCrc;
    int         mCount;

    out_handshake_sink #(.WIDTH(8), .DEPTH(DEPTH), .SELW(2), .ACK_CYCLES(1), .CRC_POLY(8'h07)) dut (
        .clk(clk), .reset(reset), .enable(enable), .freeze(freeze), .clear(clear),
        .out_start(out_start), .out_data(out_data), .out_finish(out_finish),
        .view_sel(view_sel), .view_data(view_data), .crc(crc), .byte_count(byte_count),
        .valid_count(valid_count), .full(full), .busy(busy)
    );

    out_handshake_sink #(.WIDTH(8), .DEPTH(DEPTH), .SELW(2), .ACK_CYCLES(ACK3), .CRC_POLY(8'h07)) dut3 (
        .clk(clk), .reset(reset3), .enable(one3), .freeze(zero3), .clear(zero3),
        .out_start(start3), .out_data(data3), .out_finish(finish3),
        .view_sel(sel3), .view_data(view3), .crc(crc3), .byte_count(count3),
        .valid_count(valid3), .full(full3), .busy(busy3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial long division of the accepted message stream
    function automatic logic [7:0] crcSerial(input logic [7:0] r0, input logic [7:0] d);
        logic [7:0] r;
        bit fb;
        r = r0;
        for (int b = 7; b >= 0; b--) begin
            fb = r[7] ^ d[b];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    function automatic logic [7:0] expView(input int sel);
        return (sel < mHist.size()) ? mHist[sel] : 8'h00;
    endfunction

    task automatic modelClear();
        mHist.delete();
        mCrc   = 8'h00;
        mCount = 0;
    endtask

    task automatic modelAccept(input logic [7:0] d);
        mHist.push_front(d);
        if (mHist.size() > DEPTH) void'(mHist.pop_back());
        mCrc = crcSerial(mCrc, d);
        if (mCount < 65535) mCount++;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 20; i++) begin
            if (busy) @(negedge clk);
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic checkState();
        check("crc", crc, mCrc);
        check("byte_count", byte_count, mCount);
        check("valid_count", valid_count, mHist.size());
        check("full", full, mHist.size() == DEPTH);
    endtask

    task automatic checkViews();
        for (int s = 0; s < 4; s++) begin
            view_sel = 2'(s);
            #1;
            check("view_data", view_data, expView(s));
        end
        view_sel = 2'd0;
    endtask

    task automatic doReset();
        out_start = 1'b0;
        clear     = 1'b0;
        reset     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        modelClear();
        sbq.delete();
    endtask

    // Issue one word; the monitor checks the result when the ack appears
    task automatic sendWord(input logic [7:0] d, input bit clr);
        bit  stall;
        expT e;
        int  finCount;
        waitIdle();
        stall     = freeze && (mHist.size() == DEPTH);
        out_data  = d;
        out_start = 1'b1;
        clear     = clr && !stall;
        if (!stall) begin
            if (clr) modelClear();
            else     modelAccept(d);
            e.crc = mCrc;
            e.bc  = 16'(mCount);
            e.vc  = 5'(mHist.size());
            e.v0  = expView(0);
            sbq.push_back(e);
        end
        @(negedge clk);
        clear = 1'b0;
        if (stall) begin
            finCount = 0;
            repeat (6) begin
                if (out_finish) finCount++;
                @(negedge clk);
            end
            check("stall_no_ack", finCount, 0);
            check("stall_count_held", byte_count, mCount);
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (!out_finish) @(negedge clk);
            end
            check("ack_seen", out_finish, 1'b1);
        end
        out_start = 1'b0;
    endtask

    // Monitor: pop one expectation per acknowledge pulse and check its width
    logic prevFin = 1'b0;
    int   runLen  = 0;
    always @(negedge clk) begin : monitor
        expT e;
        if (out_finish && !prevFin) begin
            if (sbq.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("sb_crc", crc, e.crc);
                check("sb_byte_count", byte_count, e.bc);
                check("sb_valid_count", valid_count, e.vc);
                check("sb_view0", view_data, e.v0);
            end
        end
        if (out_finish) begin
            runLen++;
        end else if (runLen != 0) begin
            check("ack_width", runLen, 1);
            runLen = 0;
        end
        prevFin = out_finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b1; freeze = 1'b0; clear = 1'b0;
        out_start = 1'b0; out_data = 8'h00; view_sel = 2'd0;
        reset3 = 1'b0; start3 = 1'b0; data3 = 8'h00;
        modelClear();
        repeat (2) @(negedge clk);
        check("rst_crc", crc, 0);
        check("rst_byte_count", byte_count, 0);
        check("rst_valid_count", valid_count, 0);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_finish", out_finish, 0);
        check("rst_view", view_data, 0);
        reset = 1'b1;
        reset3 = 1'b1;

        // single word
        sendWord(8'h31, 1'b0);
        waitIdle();
        check("crc_31", crc, 8'h97);
        checkState();

        // two words and view selection
        doReset();
        sendWord(8'h01, 1'b0);
        waitIdle();
        check("crc_01", crc, 8'h07);
        sendWord(8'h02, 1'b0);
        waitIdle();
        check("crc_0102", crc, 8'h1B);
        view_sel = 2'd1; #1;
        check("view1_01", view_data, 8'h01);
        view_sel = 2'd0;
        checkViews();

        // rolling history
        doReset();
        for (int w = 1; w <= 5; w++) sendWord(8'(w), 1'b0);
        waitIdle();
        checkState();
        checkViews();
        check("roll_valid", valid_count, 4);
        check("roll_bytes", byte_count, 5);
        view_sel = 2'd3; #1;
        check("roll_oldest", view_data, 8'h02);
        view_sel = 2'd0;

        // freeze stalls once full, then clear lets the word in
        doReset();
        freeze = 1'b1;
        for (int w = 1; w <= 5; w++) sendWord(8'(w), 1'b0);
        checkViews();
        check("freeze_full", full, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        modelClear();
        checkState();
        sendWord(8'h05, 1'b0);
        waitIdle();
        checkState();
        checkViews();
        freeze = 1'b0;

        // clear on the accept edge drops the word but still acks it
        doReset();
        sendWord(8'h11, 1'b0);
        sendWord(8'h22, 1'b0);
        sendWord(8'hAA, 1'b1);
        waitIdle();
        checkState();
        checkViews();

        // randomized traffic
        doReset();
        repeat (60) begin
            freeze = ($urandom_range(0, 3) == 0);
            sendWord(8'($urandom), $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) begin
                waitIdle();
                checkState();
                checkViews();
            end
        end
        freeze = 1'b0;
        waitIdle();
        checkState();

        // long acknowledge, held start, then reset in the middle of an ACK
        @(negedge clk);
        data3  = 8'h5A;
        start3 = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            check("ack3_finish", finish3, (k % (ACK3 + 2)) < ACK3);
            check("ack3_busy", busy3, (k % (ACK3 + 2)) != ACK3 + 1);
            if (k == 0) check("ack3_crc", crc3, crcSerial(8'h00, 8'h5A));
            if (k == 5) check("ack3_second_word", count3, 2);
        end
        reset3 = 1'b0;
        start3 = 1'b0;
        @(negedge clk);
        check("midack_finish", finish3, 0);
        check("midack_busy", busy3, 0);
        check("midack_count", count3, 0);
        check("midack_valid", valid3, 0);
        check("midack_crc", crc3, 0);
        reset3 = 1'b1;

        repeat (3) @(negedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
